// File: rtl/mult_hilo_unit_if.sv
// Pipeline-side bundle for the HI/LO multiplier: multiply launch, mthi/mtlo
// writes, mfhi/mflo read request, and the HI/LO/status outputs.
interface mult_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             rd_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, is_signed, op_a, op_b, wr_hi, wr_lo, wr_data, rd_req,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, is_signed, op_a, op_b, wr_hi, wr_lo, wr_data, rd_req,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/mult_hilo_unit.sv
// Iterative shift-add multiplier owning the architectural HI/LO registers.
// Signed operands are multiplied as magnitudes and the product negated at the end.
module mult_hilo_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic            clk,
    input logic            rst,
    mult_hilo_unit_if.slave bus
);
    localparam int BPC   = BITS_PER_CYCLE;
    localparam int L     = WIDTH / BPC;
    localparam int CNT_W = $clog2(L) + 1;
    localparam int PW    = WIDTH + BPC;
    localparam int AW    = 2 * WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [AW-1:0]    acc;
    logic [CNT_W-1:0] cnt;
    logic             neg;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [PW-1:0]    partial;
    logic [PW-1:0]    sum;
    logic [AW-1:0]    acc_next;
    logic [AW-1:0]    product;
    logic             last;

    // The upper half plus one partial product never exceeds WIDTH+BPC bits,
    // so the sum is kept at that width before the right shift.
    always_comb begin
        mag_a    = (bus.is_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
        mag_b    = (bus.is_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
        partial  = PW'(mcand) * PW'(mplier[BPC-1:0]);
        sum      = PW'(acc[AW-1:WIDTH]) + partial;
        acc_next = AW'({sum, acc[WIDTH-1:0]} >> BPC);
        product  = neg ? -acc_next : acc_next;
        last     = (state == RUN) && (cnt == CNT_W'(L - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        neg    <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier >> BPC;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A product landing on the same edge as mthi/mtlo wins.
            if (last) begin
                hi_q <= product[AW-1:WIDTH];
                lo_q <= product[WIDTH-1:0];
            end else begin
                if (bus.wr_hi) hi_q <= bus.wr_data;
                if (bus.wr_lo) lo_q <= bus.wr_data;
            end
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = (state == RUN);
    assign bus.done  = done_q;
    assign bus.stall = (state == RUN) & bus.rd_req;
endmodule

// File: tb/tb_mult_hilo_unit.sv
// Bench for mult_hilo_unit: 32-bit/1-bit-per-cycle main instance plus three
// 8-bit instances (1, 2 and 4 bits per cycle) checked against plain arithmetic.
module tb_mult_hilo_unit;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mult_hilo_unit_if #(.WIDTH(32)) bus ();
    mult_hilo_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic       s_start;
    logic       s_signed;
    logic [7:0] s_a;
    logic [7:0] s_b;
    logic [7:0] sw_hi   [3];
    logic [7:0] sw_lo   [3];
    logic       sw_done [3];

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        mult_hilo_unit_if #(.WIDTH(8)) sbus ();
        assign sbus.start     = s_start;
        assign sbus.is_signed = s_signed;
        assign sbus.op_a      = s_a;
        assign sbus.op_b      = s_b;
        assign sbus.wr_hi     = 1'b0;
        assign sbus.wr_lo     = 1'b0;
        assign sbus.wr_data   = 8'h00;
        assign sbus.rd_req    = 1'b0;
        mult_hilo_unit #(.WIDTH(8), .BITS_PER_CYCLE(1 << g)) u (.clk(clk), .rst(rst), .bus(sbus));
        assign sw_hi[g]   = sbus.hi;
        assign sw_lo[g]   = sbus.lo;
        assign sw_done[g] = sbus.done;
    end

    // Reference: sign- or zero-extend both operands and keep the low 2*W bits.
    function automatic logic [63:0] ref64(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [15:0] ref16(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [15:0] ea, eb;
        ea = s ? {{8{a[7]}}, a} : {8'b0, a};
        eb = s ? {{8{b[7]}}, b} : {8'b0, b};
        return ea * eb;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output int busy_n, output int done_n, output int lat);
        bus.op_a = a; bus.op_b = b; bus.is_signed = s; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        busy_n = 0; done_n = 0; lat = -1;
        for (int n = 0; n < 40; n++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                if (lat < 0) lat = n;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rd_req = 1'b1;
        tick();
        tick();
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 0", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 0", bus.lo); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall); end
        bus.rd_req = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        int bn, dn, lat;
        logic [31:0] a, b;
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, bn, dn, lat);
        checks++; if (bn !== 32) begin errors++; $display("[TB] FAIL multu_busy_cycles: got %0d expected 32", bn); end
        checks++; if (dn !== 1) begin errors++; $display("[TB] FAIL multu_done_pulses: got %0d expected 1", dn); end
        checks++; if (lat !== 32) begin errors++; $display("[TB] FAIL multu_latency: got %0d expected 32", lat); end
        checks++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFE_00000001) begin errors++; $display("[TB] FAIL multu_max: got %h expected FFFFFFFE00000001", {bus.hi, bus.lo}); end
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom;
            run_mul(a, b, 1'b0, bn, dn, lat);
            checks++; if ({bus.hi, bus.lo} !== ref64(a, b, 1'b0)) begin errors++; $display("[TB] FAIL multu_rand %h*%h: got %h expected %h", a, b, {bus.hi, bus.lo}, ref64(a, b, 1'b0)); end
        end
    endtask

    task automatic test_signed();
        int bn, dn, lat;
        logic [31:0] va [3] = '{32'hFFFFFFFD, 32'h80000000, 32'h80000000};
        logic [31:0] vb [3] = '{32'h00000005, 32'h80000000, 32'h00000002};
        logic        vs [3] = '{1'b1, 1'b1, 1'b0};
        logic [63:0] vp [3] = '{64'hFFFFFFFF_FFFFFFF1, 64'h40000000_00000000, 64'h00000001_00000000};
        logic [31:0] a, b;
        for (int i = 0; i < 3; i++) begin
            run_mul(va[i], vb[i], vs[i], bn, dn, lat);
            checks++; if ({bus.hi, bus.lo} !== vp[i]) begin errors++; $display("[TB] FAIL signed_vec%0d: got %h expected %h", i, {bus.hi, bus.lo}, vp[i]); end
        end
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom;
            if (i == 0) a = 32'h80000000;
            run_mul(a, b, 1'b1, bn, dn, lat);
            checks++; if ({bus.hi, bus.lo} !== ref64(a, b, 1'b1)) begin errors++; $display("[TB] FAIL mult_rand %h*%h: got %h expected %h", a, b, {bus.hi, bus.lo}, ref64(a, b, 1'b1)); end
            checks++; if (lat !== 32 || dn !== 1) begin errors++; $display("[TB] FAIL mult_rand_timing: got lat %0d pulses %0d expected 32/1", lat, dn); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] a, b;
        logic [63:0] exp;
        logic        exp_stall;
        a = $urandom; b = $urandom; exp = ref64(a, b, 1'b0);
        bus.op_a = a; bus.op_b = b; bus.is_signed = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 0; n <= 33; n++) begin
            if (n == 3) bus.rd_req = 1'b1;
            #1;
            exp_stall = (n >= 3) && (n < 32);
            checks++; if (bus.stall !== exp_stall) begin errors++; $display("[TB] FAIL stall_n%0d: got %b expected %b", n, bus.stall, exp_stall); end
            if (n == 32) begin
                checks++; if (bus.done !== 1'b1 || bus.lo !== exp[31:0]) begin errors++; $display("[TB] FAIL stall_read: got done %b lo %h expected 1 %h", bus.done, bus.lo, exp[31:0]); end
            end
            tick();
        end
        bus.rd_req = 1'b0;
    endtask

    task automatic test_writes();
        logic [31:0] a, b;
        logic [63:0] exp;
        bus.wr_hi = 1'b1; bus.wr_data = 32'h12345678;
        tick();
        bus.wr_hi = 1'b0;
        checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("[TB] FAIL mthi_idle: got %h expected 12345678", bus.hi); end
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'hA5A5C3C3;
        tick();
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        checks++; if ({bus.hi, bus.lo} !== 64'hA5A5C3C3_A5A5C3C3) begin errors++; $display("[TB] FAIL mthi_mtlo_both: got %h expected A5A5C3C3A5A5C3C3", {bus.hi, bus.lo}); end
        a = $urandom; b = $urandom; exp = ref64(a, b, 1'b1);
        bus.op_a = a; bus.op_b = b; bus.is_signed = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 0; n <= 33; n++) begin
            if (n == 6) begin
                checks++; if ({bus.hi, bus.lo} !== 64'hDEADBEEF_DEADBEEF || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL write_in_run: got %h busy %b expected DEADBEEFDEADBEEF busy 1", {bus.hi, bus.lo}, bus.busy); end
                bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
            end
            if (n == 11) bus.start = 1'b0;
            if (n == 32) begin
                checks++; if ({bus.hi, bus.lo} !== exp || bus.done !== 1'b1) begin errors++; $display("[TB] FAIL write_on_completion: got %h done %b expected %h done 1", {bus.hi, bus.lo}, bus.done, exp); end
                bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
            end
            if (n == 33) begin
                checks++; if ({bus.hi, bus.lo} !== exp || bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL start_in_run_ignored: got %h busy %b done %b expected %h 0 0", {bus.hi, bus.lo}, bus.busy, bus.done, exp); end
            end
            if (n == 5) begin bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'hDEADBEEF; end
            if (n == 10) begin bus.start = 1'b1; bus.op_a = 32'h0; bus.op_b = 32'h0; end
            if (n == 31) begin bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'hCAFEF00D; end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int bn, dn, lat, dcount;
        bus.op_a = $urandom | 32'h1; bus.op_b = $urandom | 32'h1; bus.is_signed = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 0; n < 10; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid: got busy %b hi %h lo %h done %b expected 0 0 0 0", bus.busy, bus.hi, bus.lo, bus.done); end
        dcount = 0;
        for (int n = 0; n < 40; n++) begin
            if (bus.done) dcount++;
            tick();
        end
        checks++; if (dcount !== 0 || bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_mid_no_done: got %0d pulses lo %h expected 0 pulses lo 0", dcount, bus.lo); end
        run_mul(32'd7, 32'd6, 1'b0, bn, dn, lat);
        checks++; if (bus.lo !== 32'd42 || bus.hi !== 32'd0) begin errors++; $display("[TB] FAIL after_reset_7x6: got %h_%h expected 0_2a", bus.hi, bus.lo); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2;
        logic [63:0] e1, e2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        e1 = ref64(a1, b1, 1'b1); e2 = ref64(a2, b2, 1'b0);
        bus.op_a = a1; bus.op_b = b1; bus.is_signed = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 0; n < 32; n++) tick();
        checks++; if ({bus.hi, bus.lo} !== e1 || bus.done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first: got %h done %b expected %h done 1", {bus.hi, bus.lo}, bus.done, e1); end
        bus.op_a = a2; bus.op_b = b2; bus.is_signed = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_restart: got busy %b done %b expected 1 0", bus.busy, bus.done); end
        for (int n = 0; n < 32; n++) tick();
        checks++; if ({bus.hi, bus.lo} !== e2 || bus.done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second: got %h done %b expected %h done 1", {bus.hi, bus.lo}, bus.done, e2); end
        tick();
    endtask

    task automatic test_param_sweep();
        int lat [3];
        logic [15:0] exp;
        logic [7:0] ta [4] = '{8'h80, 8'hFF, 8'h80, 8'h7F};
        logic [7:0] tb [4] = '{8'h80, 8'hFF, 8'h02, 8'h81};
        logic       ts [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 24; t++) begin
            if (t < 4) begin s_a = ta[t]; s_b = tb[t]; s_signed = ts[t]; end
            else begin s_a = 8'($urandom); s_b = 8'($urandom); s_signed = 1'($urandom_range(0, 1)); end
            exp = ref16(s_a, s_b, s_signed);
            s_start = 1'b1;
            tick();
            s_start = 1'b0;
            for (int g = 0; g < 3; g++) lat[g] = -1;
            for (int n = 0; n < 10; n++) begin
                for (int g = 0; g < 3; g++) begin
                    if (sw_done[g] && lat[g] < 0) begin
                        lat[g] = n;
                        checks++; if ({sw_hi[g], sw_lo[g]} !== exp) begin errors++; $display("[TB] FAIL sweep_bpc%0d %h*%h s%b: got %h expected %h", 1 << g, s_a, s_b, s_signed, {sw_hi[g], sw_lo[g]}, exp); end
                    end
                end
                tick();
            end
            for (int g = 0; g < 3; g++) begin
                checks++; if (lat[g] !== (8 >> g)) begin errors++; $display("[TB] FAIL sweep_latency_bpc%0d: got %0d expected %0d", 1 << g, lat[g], 8 >> g); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.op_a = '0; bus.op_b = '0;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0; bus.rd_req = 1'b0;
        s_start = 1'b0; s_signed = 1'b0; s_a = '0; s_b = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_stall();
        test_writes();
        test_reset_mid();
        test_back_to_back();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/mult_hilo_unit.md
# mult_hilo_unit

Parametrised iterative multiplier with architectural HI/LO registers for the pipelined CPU's EX stage, implementing `mult`, `multu`, `mfhi`, `mflo`, `mthi` and `mtlo`. It runs a multi-cycle shift-add sequence beside the single-cycle ALU. It raises a stall request when the pipeline tries to read HI/LO before a product is ready. Width and throughput (bits retired per cycle) are parameters, and signed multiply is supported, which the current integrated multiplier does not offer.

## Interface
- `WIDTH`, default 32: operand width. Must be even and ≥ 4. HI and LO are each `WIDTH` bits.
- `BITS_PER_CYCLE`, default 1: multiplier bits consumed per iteration. Must be 1, 2 or 4 and divide `WIDTH`.
- Derived constant: L = `WIDTH`/`BITS_PER_CYCLE` iterations.

Ports:
- `clk`  in  1  the single clock. All state changes on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  begin a multiply with `op_a`/`op_b`. Sampled only in IDLE.
- `is_signed`  in  1  1 selects `mult` (two's complement), 0 selects `multu`. Sampled with `start`.
- `op_a`  in  WIDTH  multiplicand.
- `op_b`  in  WIDTH  multiplier.
- `wr_hi`  in  1  `mthi`: write `wr_data` to HI.
- `wr_lo`  in  1  `mtlo`: write `wr_data` to LO.
- `wr_data`  in  WIDTH  data for `mthi`/`mtlo`.
- `rd_req`  in  1  an `mfhi`/`mflo` is in EX this cycle.
- `hi`  out  WIDTH  HI register, registered.
- `lo`  out  WIDTH  LO register, registered.
- `busy`  out  1  a multiply is in progress (state RUN).
- `done`  out  1  one-cycle pulse, high in the cycle after HI/LO receive a product.
- `stall`  out  1  combinational, equal to `busy & rd_req`. Freezes the PC, IF/ID and ID/EX registers and inserts a bubble into EX/MEM.

## Operation
- States: IDLE and RUN.
- IDLE with `start`=1:
  - Latch the magnitudes |op_a| and |op_b| (the raw values when `is_signed`=0).
  - Latch neg = `is_signed` & (op_a[MSB] ^ op_b[MSB]).
  - Clear the 2·WIDTH accumulator and the iteration counter, then go to RUN.
- RUN, each cycle:
  - Add multiplicand × (low `BITS_PER_CYCLE` bits of the multiplier) into the upper accumulator half.
  - Shift the accumulator and the multiplier right by `BITS_PER_CYCLE`.
  - Increment the counter.
- On the edge that completes iteration L:
  - Load {HI,LO} with the accumulator, two's-complement negated over 2·WIDTH bits if neg.
  - Go to IDLE and set `done` for the next cycle.
- Magnitude of the most negative value (e.g. 0x80000000) is taken as unsigned 2^(WIDTH-1). The product is exact in 2·WIDTH bits, so no overflow is possible.
- `start` in RUN is ignored: no queueing and no error. The pipeline must not issue it, because `stall` only covers reads.
- `wr_hi` and `wr_lo` update their register on the next edge in either state.
  - Simultaneous `wr_hi` and `wr_lo` write both registers.
  - If a write coincides with the completion edge, the product wins and the write is dropped.
  - A write during RUN is visible until completion, then overwritten.
- `hi`/`lo` always show the current register contents. Reads are not blocked in IDLE.

## Timing
- Reset: on a `rst`=1 edge, `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, and the counter and accumulator are cleared. Reset takes priority over `start` and over writes.
- Reset mid-RUN aborts the multiply: no product is written and `done` does not fire.
- Multiply timeline, with `start` sampled at edge k:
  - `busy` is 1 in the cycles after edges k … k+L-1 (L cycles).
  - HI/LO hold the product after edge k+L.
  - `done` is 1 for exactly the cycle after edge k+L.
- Latency: L cycles from the `start` edge to the result. With defaults, L = 32; with `BITS_PER_CYCLE`=4, L = 8.
- Back-to-back: a new `start` may be sampled at edge k+L+1, i.e. while `done` is high.
- `stall` has zero-cycle response. An `mfhi` held in EX by `stall` reads the product in the `done` cycle.

## Test plan
- Reset, then unsigned multiply: `multu` 0xFFFFFFFF × 0xFFFFFFFF.
  - `busy` is high for exactly 32 cycles.
  - Result HI=0xFFFFFFFE, LO=0x00000001.
  - `done` pulses once.
- Signed multiplies:
  - `mult` -3 × 5 gives HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - `mult` 0x80000000 × 0x80000000 gives HI=0x40000000, LO=0.
  - `multu` 0x80000000 × 2 gives HI=1, LO=0.
- Stall on read: assert `rd_req` 3 cycles after `start`.
  - `stall`=1 until the `done` cycle, then 0.
  - `lo` equals the product in that `done` cycle.
- Writes: `mthi` 0x12345678 in IDLE updates `hi` after one edge.
  - A write during RUN is visible, then replaced by the product.
  - A write on the completion edge is lost.
  - A `start` pulse during RUN changes nothing.
- Reset mid-operation: assert `rst` at iteration 10 of a multiply.
  - Next cycle shows `busy`=0, `hi`=`lo`=0, and no `done`.
  - A following multiply of 7 × 6 gives LO=42.
- Parameter sweep, `WIDTH`=8 with `BITS_PER_CYCLE`=1, 2, 4 (random signed and unsigned operands):
  - Latency is 8, 4 and 2 cycles respectively.
  - Every result matches a reference 16-bit product.
